// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: push side from IF, pop side toward ID, pipeline control and status.
//   slave  : queue side (takes i_* signals, drives o_* signals)
//   master : environment side (drives i_* signals, observes o_* signals)
interface fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              i_push_valid;
  logic [ADDR_W-1:0] i_push_pc;
  logic [DATA_W-1:0] i_push_inst;
  logic              o_push_ready;
  logic              o_pop_valid;
  logic [ADDR_W-1:0] o_pc_addr;
  logic [DATA_W-1:0] o_inst_data;
  logic              i_pop_ready;
  logic [1:0]        i_hold_flag;
  logic [CNT_W-1:0]  o_count;
  logic              o_drop;

  modport slave (
    input  i_push_valid, i_push_pc, i_push_inst, i_pop_ready, i_hold_flag,
    output o_push_ready, o_pop_valid, o_pc_addr, o_inst_data, o_count, o_drop
  );

  modport master (
    output i_push_valid, i_push_pc, i_push_inst, i_pop_ready, i_hold_flag,
    input  o_push_ready, o_pop_valid, o_pc_addr, o_inst_data, o_count, o_drop
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue between IF and ID: DEPTH-entry circular buffer of {pc, inst}
// with hold/flush pipeline control and a sticky overflow flag.
// Ports:
//   i_Clk   : clock, all state changes on the rising edge
//   i_reset : synchronous active-low reset
//   bus     : fetch_queue_if.slave (push handshake, pop handshake,
//             i_hold_flag 00 run / 01 hold / 1x flush, o_count, o_drop)
// Every output is a flop; the head entry is precomputed for the next cycle.
module fetch_queue #(
  parameter int unsigned              ADDR_W   = 32,
  parameter int unsigned              DATA_W   = 32,
  parameter int unsigned              DEPTH    = 4,
  parameter logic [DATA_W-1:0]        NOP_WORD = DATA_W'(32'h0000_0013)
) (
  input  logic          i_Clk,
  input  logic          i_reset,
  fetch_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // Storage (not reset; stale contents are never exposed)
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [DATA_W-1:0] r_mem_inst [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_push_ready;
  logic              r_pop_valid;
  logic [ADDR_W-1:0] r_pc_addr;
  logic [DATA_W-1:0] r_inst_data;
  logic              r_drop;

  logic              w_flush;
  logic              w_run;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_wr_next;
  logic [PTR_W-1:0]  w_rd_next;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_drop_next;
  logic [ADDR_W-1:0] w_pc_next;
  logic [DATA_W-1:0] w_inst_next;

  // Next-state computation for pointers, count, flags and head outputs
  always_comb begin
    w_flush      = bus.i_hold_flag[1];
    w_run        = (bus.i_hold_flag == 2'b00);
    w_push       = bus.i_push_valid & r_push_ready & ~w_flush;
    w_pop        = r_pop_valid & bus.i_pop_ready & w_run;
    w_wr_next    = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    w_rd_next    = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_drop_next  = r_drop | (bus.i_push_valid & ~r_push_ready & ~w_flush);
    if (w_flush) begin
      w_wr_next    = '0;
      w_rd_next    = '0;
      w_count_next = '0;
    end

    w_pc_next   = '0;
    w_inst_next = NOP_WORD;
    if (w_count_next != '0) begin
      // The new head is the entry being written this cycle only when the
      // queue would otherwise be empty; a push never targets a full queue.
      if (w_push && (r_wr_ptr == w_rd_next)) begin
        w_pc_next   = bus.i_push_pc;
        w_inst_next = bus.i_push_inst;
      end else begin
        w_pc_next   = r_mem_pc[w_rd_next];
        w_inst_next = r_mem_inst[w_rd_next];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge i_Clk) begin
    if (!i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_push_ready <= 1'b1;
      r_pop_valid  <= 1'b0;
      r_pc_addr    <= '0;
      r_inst_data  <= NOP_WORD;
      r_drop       <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_next;
      r_rd_ptr     <= w_rd_next;
      r_count      <= w_count_next;
      r_push_ready <= (w_count_next < CNT_W'(DEPTH));
      r_pop_valid  <= (w_count_next != '0);
      r_pc_addr    <= w_pc_next;
      r_inst_data  <= w_inst_next;
      r_drop       <= w_drop_next;
    end
  end

  // Entry write; gated by reset so a push in a reset cycle has no effect
  always_ff @(posedge i_Clk) begin
    if (i_reset && w_push) begin
      r_mem_pc[r_wr_ptr]   <= bus.i_push_pc;
      r_mem_inst[r_wr_ptr] <= bus.i_push_inst;
    end
  end

  assign bus.o_push_ready = r_push_ready;
  assign bus.o_pop_valid  = r_pop_valid;
  assign bus.o_pc_addr    = r_pc_addr;
  assign bus.o_inst_data  = r_inst_data;
  assign bus.o_count      = r_count;
  assign bus.o_drop       = r_drop;
endmodule
